pulse_hs_tx: RTL and testbench

PULSE_HS_TX -- requirements
Module: pulse_hs_tx

---
 rtl/pulse_hs_pkg.sv | 14 +
 rtl/sync_chain.sv | 28 ++
 rtl/pulse_hs_tx.sv | 130 +++++++++++++
 tb/tb_pulse_hs_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_hs_pkg.sv
// Shared definitions for the pulse_hs_tx handshake transmitter.
//   hs_state_t       : four-phase handshake FSM state encoding
//   SYNC_STAGES_MIN  : smallest synchronizer depth the transmitter will build
package pulse_hs_pkg;

    localparam int SYNC_STAGES_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } hs_state_t;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop level synchronizer with asynchronous clear.
// Ports:
//   clk : destination clock
//   clr : asynchronous, active-high clear (all stages to 0)
//   d   : asynchronous input level
//   q   : synchronized level, STAGES clk edges behind d
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_hs_tx.sv
// Event-to-level four-phase handshake transmitter.
// Single-cycle events on evt_in are turned into req/ack handshakes towards a
// far clock domain. Events arriving while a handshake is in flight are held
// in a pending store and launched one per handshake.
//
// Ports:
//   clk     : source-domain clock
//   clr     : asynchronous, active-high reset
//   evt_in  : single-cycle event strobe (clk domain)
//   ack_in  : acknowledge level from far domain (asynchronous)
//   req_out : registered request level to far domain
//   busy    : high while a handshake is in progress
//   pending : accepted events not yet launched
//   done    : one-cycle pulse when a handshake completes
//   drop    : one-cycle pulse when an event is lost
//
// Build option: PULSE_HS_TX_QUEUE_EN
//   defined   : pending is a saturating counter up to 2^PEND_W-1
//   undefined : pending is a 1-deep flag (0 or 1), upper bits stay 0
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | req_out low, waiting for work and ack_s low
// ST_REQ     | req_out high, waiting for ack_s high
// ST_RELEASE | req_out low, waiting for ack_s low to finish
module pulse_hs_tx
    import pulse_hs_pkg::*;
#(
    parameter int PEND_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              evt_in,
    input  logic              ack_in,
    output logic              req_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              done,
    output logic              drop
);

    localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

`ifdef PULSE_HS_TX_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
`else
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(1);
`endif

    hs_state_t         state;
    logic              ack_s;
    logic              launch;
    logic              take_pend;
    logic [PEND_W-1:0] pend_nxt;
    logic              drop_nxt;

    sync_chain #(
        .STAGES (SYNC_N)
    ) u_ack_sync (
        .clk (clk),
        .clr (clr),
        .d   (ack_in),
        .q   (ack_s)
    );

    // A stale ack (ack_s still high) blocks launching; events keep queuing.
    assign launch    = (state == ST_IDLE) && (evt_in || (pending != '0)) && !ack_s;
    assign take_pend = launch && (pending != '0);

    // A launch consumes exactly one event: the oldest pending one if any,
    // otherwise the event arriving this cycle. Net change is therefore
    // -1 (pending launched, no new event), 0, or +1 (event, no launch).
    always_comb begin
        pend_nxt = pending;
        drop_nxt = 1'b0;
        if (take_pend && !evt_in) begin
            pend_nxt = pending - PEND_W'(1);
        end else if (evt_in && !launch) begin
            if (pending == PEND_MAX) begin
                drop_nxt = 1'b1;
            end else begin
                pend_nxt = pending + PEND_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= ST_IDLE;
            req_out <= 1'b0;
            busy    <= 1'b0;
            pending <= '0;
            done    <= 1'b0;
            drop    <= 1'b0;
        end else begin
            done    <= 1'b0;
            drop    <= drop_nxt;
            pending <= pend_nxt;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state   <= ST_REQ;
                        req_out <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ack_s) begin
                        state   <= ST_RELEASE;
                        req_out <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    if (!ack_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    req_out <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_hs_tx.sv
// Directed self-checking bench for pulse_hs_tx (PEND_W=4, SYNC_STAGES=2).
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_pulse_hs_tx;

    localparam int PEND_W = 4;
    localparam int SYNC_STAGES = 2;
`ifdef PULSE_HS_TX_QUEUE_EN
    localparam int PMAX = 15;
`else
    localparam int PMAX = 1;
`endif

    logic              clk;
    logic              clr;
    logic              evt_in;
    logic              ack_in;
    logic              req_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              done;
    logic              drop;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int drop_cnt = 0;
    int pend_nz_cnt = 0;

    pulse_hs_tx #(
        .PEND_W      (PEND_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .evt_in  (evt_in),
        .ack_in  (ack_in),
        .req_out (req_out),
        .busy    (busy),
        .pending (pending),
        .done    (done),
        .drop    (drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    // Pulse/event monitor: sole writer of the counters below.
    initial begin
        forever begin
            @(negedge clk);
            if (!clr) begin
                if (done === 1'b1) done_cnt++;
                if (drop === 1'b1) drop_cnt++;
                if (pending !== '0) pend_nz_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_req(input logic lvl, input string tag);
        int i = 0;
        while (req_out !== lvl && i < 60) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(req_out), 32'(lvl));
    endtask

    // Responder: ack 5 cycles after seeing req, release after req drops,
    // return on the falling edge where done is high.
    task automatic do_handshake(input string tag);
        int i = 0;
        wait_req(1'b1, {tag, "_req_hi"});
        repeat (5) @(negedge clk);
        ack_in = 1'b1;
        wait_req(1'b0, {tag, "_req_lo"});
        ack_in = 1'b0;
        while (done !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic evt_burst(input int k);
        @(negedge clk);
        evt_in = 1'b1;
        repeat (k) @(negedge clk);
        evt_in = 1'b0;
    endtask

    int d0, dr0, nz0, n_hs;

    initial begin
        clr = 1'b1;
        evt_in = 1'b0;
        ack_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(req_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        clr = 1'b0;
        repeat (2) @(negedge clk);

        // Single event, launch latency, full handshake.
        d0 = done_cnt; nz0 = pend_nz_cnt;
        @(negedge clk);
        evt_in = 1'b1;
        check("lat_pre_req", 32'(req_out), 32'd0);
        @(negedge clk);
        evt_in = 1'b0;
        check("lat_req", 32'(req_out), 32'd1);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_pending", 32'(pending), 32'd0);
        do_handshake("single");
        repeat (3) @(negedge clk);
        check("single_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("single_busy", 32'(busy), 32'd0);
        check("single_pend_nz", 32'(pend_nz_cnt - nz0), 32'd0);

        // Three back-to-back events from IDLE.
        d0 = done_cnt; dr0 = drop_cnt;
        n_hs = (PMAX >= 2) ? 3 : 2;
        @(negedge clk);
        evt_in = 1'b1;
        @(negedge clk);
        check("burst3_p0", 32'(pending), 32'd0);
        @(negedge clk);
        check("burst3_p1", 32'(pending), 32'd1);
        @(negedge clk);
        evt_in = 1'b0;
        check("burst3_p2", 32'(pending), 32'(n_hs - 1));
        for (int i = 0; i < n_hs; i++) begin
            do_handshake("burst3");
            @(negedge clk);
            if (i < n_hs - 1) begin
                check("burst3_relaunch", 32'(req_out), 32'd1);
                check("burst3_dec", 32'(pending), 32'(n_hs - 2 - i));
            end
        end
        repeat (2) @(negedge clk);
        check("burst3_idle", 32'(busy), 32'd0);
        check("burst3_done_cnt", 32'(done_cnt - d0), 32'(n_hs));
        check("burst3_drop_cnt", 32'(drop_cnt - dr0), 32'(3 - n_hs));

        // Saturation: responder silent, FSM parked in REQ, 20 more events.
        pulse_clr();
        evt_burst(1);
        @(negedge clk);
        check("sat_in_req", 32'(req_out), 32'd1);
        dr0 = drop_cnt;
        evt_burst(20);
        @(negedge clk);
        check("sat_pending", 32'(pending), 32'(PMAX));
        check("sat_drop_cnt", 32'(drop_cnt - dr0), 32'(20 - PMAX));

        // Async reset in REQ with events pending.
        pulse_clr();
        evt_burst(1);
        evt_burst(3);
        @(negedge clk);
        check("clr_setup_pend", 32'(pending), 32'((PMAX >= 3) ? 3 : PMAX));
        check("clr_setup_req", 32'(req_out), 32'd1);
        #2;
        clr = 1'b1;
        #1;
        check("clr_async_req", 32'(req_out), 32'd0);
        check("clr_async_pend", 32'(pending), 32'd0);
        check("clr_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        check("clr_after_req", 32'(req_out), 32'd0);

        // Stale ack at reset release blocks launch until it clears.
        @(negedge clk);
        clr = 1'b1;
        ack_in = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        repeat (4) @(negedge clk);
        evt_burst(1);
        repeat (3) @(negedge clk);
        check("stale_no_launch", 32'(req_out), 32'd0);
        check("stale_pend", 32'(pending), 32'd1);
        ack_in = 1'b0;
        for (int i = 0; i < SYNC_STAGES; i++) begin
            @(negedge clk);
            check("stale_sync_wait", 32'(req_out), 32'd0);
        end
        @(negedge clk);
        check("stale_launch", 32'(req_out), 32'd1);
        check("stale_pend_after", 32'(pending), 32'd0);
        do_handshake("stale");

        // Event coincident with a launch out of the pending store.
        pulse_clr();
        evt_burst(1);
        evt_burst(2);
        @(negedge clk);
        check("coin_setup_pend", 32'(pending), 32'((PMAX >= 2) ? 2 : PMAX));
        do_handshake("coin");
        evt_in = 1'b1;
        @(negedge clk);
        evt_in = 1'b0;
        check("coin_req", 32'(req_out), 32'd1);
        check("coin_pend", 32'(pending), 32'((PMAX >= 2) ? 2 : PMAX));
        check("coin_drop", 32'(drop), 32'd0);

        pulse_clr();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
